// File: rtl/pump_pkg.sv
// Shared command codes and FSM state encoding for the SPI data pump.
package pump_pkg;

    localparam logic [7:0] CMD_START = 8'h55;
    localparam logic [7:0] CMD_DATA  = 8'h56;
    localparam logic [7:0] CMD_END   = 8'h57;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_START_IDX,
        ST_DATA,
        ST_IGNORE
    } pump_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input with single-cycle
// rise/fall pulses generated in the destination clock domain.
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              w_level;

    assign w_level = r_sync[STAGES-1];

    // Shift the async input through the sync chain and keep the previous level.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= w_level;
        end
    end

    assign o_rise = w_level & ~r_prev;
    assign o_fall = ~w_level & r_prev;

endmodule

// File: rtl/spi_data_pump.sv
// SPI-slave receiver turning MCU download frames into a byte-wide ioctl
// write stream, and returning the pump status byte on MISO.
module spi_data_pump
    import pump_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              spi_sck_i,
    input  logic              spi_ss_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    input  logic [7:0]        pump_i,
    output logic              ioctl_downl_o,
    output logic [7:0]        ioctl_index_o,
    output logic [ADDR_W-1:0] ioctl_addr_o,
    output logic [7:0]        ioctl_dout_o,
    output logic              ioctl_wr_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic                   w_sck_rise, w_sck_fall;
    logic                   w_ss_rise, w_ss_fall;
    logic                   w_mosi;
    logic                   w_shifting;
    logic                   w_byte_done;
    logic [7:0]             w_byte;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [7:0]             r_shift;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_miso_sh;
    logic                   r_downl;
    logic [7:0]             r_index;
    logic [ADDR_W-1:0]      r_addr;
    logic [7:0]             r_dout;
    logic                   r_wr;
    pump_state_e            r_state, w_state_nxt;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_async   (spi_sck_i),
        .o_rise    (w_sck_rise),
        .o_fall    (w_sck_fall)
    );

    // SS_N idles high, so its chain resets to 1 to avoid a phantom edge.
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_async   (spi_ss_n_i),
        .o_rise    (w_ss_rise),
        .o_fall    (w_ss_fall)
    );

    // MOSI synchronizer with the same depth as SCK so data lines up with the rise pulse.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_mosi_sync <= '0;
        else            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
    end

    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_shifting  = w_sck_rise && (r_state != ST_IDLE);
    assign w_byte      = {r_shift[6:0], w_mosi};
    assign w_byte_done = w_shifting && (r_bitcnt == 3'd7);

    // Receive shift register and bit counter; frame boundaries drop partial bytes.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else if (w_ss_fall || w_ss_rise) begin
            r_bitcnt <= '0;
        end else if (w_shifting) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // FSM next state: command byte selects how the rest of the frame is handled.
    always_comb begin
        w_state_nxt = r_state;
        if (w_ss_rise) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      if (w_ss_fall) w_state_nxt = ST_CMD;
                ST_CMD: begin
                    if (w_byte_done) begin
                        case (w_byte)
                            CMD_START: w_state_nxt = ST_START_IDX;
                            CMD_DATA:  w_state_nxt = ST_DATA;
                            CMD_END:   w_state_nxt = ST_IDLE;
                            default:   w_state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_START_IDX: if (w_byte_done) w_state_nxt = ST_IGNORE;
                ST_DATA:      w_state_nxt = ST_DATA;
                ST_IGNORE:    w_state_nxt = ST_IGNORE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ioctl side: index/download control, write strobe and post-write address step.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_downl <= 1'b0;
            r_index <= '0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            if (r_wr)
                r_addr <= r_addr + ADDR_ONE;
            if (r_state == ST_DATA && w_byte_done && r_downl) begin
                r_wr   <= 1'b1;
                r_dout <= w_byte;
            end
            if (r_state == ST_CMD && w_byte_done && w_byte == CMD_END)
                r_downl <= 1'b0;
            if (r_state == ST_START_IDX && w_byte_done) begin
                r_index <= w_byte;
                r_addr  <= '0;
                r_downl <= 1'b1;
            end
        end
    end

    // MISO: status snapshot at frame start, shifted out only during the command byte.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_miso_sh <= '0;
        else if (w_ss_fall)
            r_miso_sh <= pump_i;
        else if (r_state != ST_CMD)
            r_miso_sh <= '0;
        else if (w_sck_fall)
            r_miso_sh <= {r_miso_sh[6:0], 1'b0};
    end

    assign spi_miso_o    = r_miso_sh[7];
    assign ioctl_downl_o = r_downl;
    assign ioctl_index_o = r_index;
    assign ioctl_addr_o  = r_addr;
    assign ioctl_dout_o  = r_dout;
    assign ioctl_wr_o    = r_wr;

endmodule

// File: tb/tb_spi_data_pump.sv
// Self-checking bench for spi_data_pump (ADDR_W=4 to reach address wrap).
module tb_spi_data_pump;

    localparam int AW   = 4;
    localparam int HALF = 60;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sck = 1'b0;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [7:0]    pump = 8'h00;
    logic          downl;
    logic [7:0]    index;
    logic [AW-1:0] addr;
    logic [7:0]    dout;
    logic          wr;

    spi_data_pump #(.ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .spi_sck_i     (sck),
        .spi_ss_n_i    (ss_n),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .pump_i        (pump),
        .ioctl_downl_o (downl),
        .ioctl_index_o (index),
        .ioctl_addr_o  (addr),
        .ioctl_dout_o  (dout),
        .ioctl_wr_o    (wr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic              m_downl = 1'b0;
    logic [7:0]        m_idx   = 8'h00;
    int                m_addr  = 0;
    logic [AW+7:0]     exp_q[$];
    logic [AW+7:0]     got_q[$];

    logic [7:0] f_bytes [0:23];
    logic [7:0] f_rx    [0:23];

    // Write-strobe monitor
    logic          prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [AW-1:0] nxt_addr;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_wr = 1'b0;
        end else begin
            if (prev_wr) begin
                nxt_addr = prev_addr + 1'b1;
                check("addr_step", 32'(addr), 32'(nxt_addr));
            end
            if (wr) begin
                check("wr_1cycle", 32'(prev_wr), 32'd0);
                check("wr_downl", 32'(downl), 32'd1);
                got_q.push_back({addr, dout});
            end
            prev_wr   = wr;
            prev_addr = addr;
        end
    end

    task automatic model_frame(input int n);
        if (n == 0) return;
        case (f_bytes[0])
            8'h55: if (n >= 2) begin m_downl = 1'b1; m_idx = f_bytes[1]; m_addr = 0; end
            8'h56: for (int i = 1; i < n; i++)
                       if (m_downl) begin
                           exp_q.push_back({AW'(m_addr), f_bytes[i]});
                           m_addr = (m_addr + 1) % (1 << AW);
                       end
            8'h57: m_downl = 1'b0;
            default: ;
        endcase
    endtask

    task automatic xfer(input logic [7:0] tx, input int nb, input bit pmid, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nb; b++) begin
            mosi = tx[7-b];
            #HALF;
            rx = {rx[6:0], miso};
            if (pmid && b == 4) pump = 8'hFF;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int n, input int partial, input logic [7:0] pmp, input bit pmid);
        logic [7:0] rx;
        @(negedge clk);
        pump = pmp;
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            xfer(f_bytes[i], 8, pmid && i == 0, rx);
            f_rx[i] = rx;
        end
        if (partial > 0) xfer(f_bytes[n], partial, 1'b0, rx);
        #HALF;
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
        model_frame(n);
    endtask

    task automatic compare_frame(input string tag, input logic [7:0] pmp, input int n);
        logic [7:0] rest;
        rest = 8'h00;
        for (int i = 1; i < n; i++) rest |= f_rx[i];
        if (n > 0) check({tag, "_miso_cmd"}, 32'(f_rx[0]), 32'(pmp));
        check({tag, "_miso_rest"}, 32'(rest), 32'd0);
        check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_wr_addr_data"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_downl"}, 32'(downl), 32'(m_downl));
        check({tag, "_index"}, 32'(index), 32'(m_idx));
        check({tag, "_addr"}, 32'(addr), 32'(m_addr));
        got_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [0:5][7:0] b;
        int              n;
        int              partial;
        logic [7:0]      pmp;
        bit              pmid;
        logic            e_downl;
        logic [7:0]      e_idx;
        logic [AW-1:0]   e_addr;
        int              e_nwr;
    } vec_t;

    vec_t vecs [0:8];

    initial begin
        logic [7:0] rx;
        int n, partial;
        logic [7:0] pmp;

        vecs[0] = '{b:{8'h55, 8'h03, 32'h0},                n:2, partial:0, pmp:8'h3F, pmid:1, e_downl:1, e_idx:8'h03, e_addr:0, e_nwr:0};
        vecs[1] = '{b:{8'h56, 8'hA1, 8'hB2, 8'hC3, 16'h0},  n:4, partial:0, pmp:8'h12, pmid:0, e_downl:1, e_idx:8'h03, e_addr:3, e_nwr:3};
        vecs[2] = '{b:{8'h57, 40'h0},                       n:1, partial:0, pmp:8'h80, pmid:0, e_downl:0, e_idx:8'h03, e_addr:3, e_nwr:0};
        vecs[3] = '{b:{8'h56, 8'h11, 8'h22, 24'h0},         n:3, partial:0, pmp:8'hA5, pmid:0, e_downl:0, e_idx:8'h03, e_addr:3, e_nwr:0};
        vecs[4] = '{b:{8'h55, 8'h07, 8'h99, 24'h0},         n:3, partial:0, pmp:8'h01, pmid:0, e_downl:1, e_idx:8'h07, e_addr:0, e_nwr:0};
        vecs[5] = '{b:{8'h56, 8'h44, 8'h77, 24'h0},         n:2, partial:5, pmp:8'h5A, pmid:0, e_downl:1, e_idx:8'h07, e_addr:1, e_nwr:1};
        vecs[6] = '{b:{8'h56, 8'h55, 32'h0},                n:2, partial:0, pmp:8'hC0, pmid:0, e_downl:1, e_idx:8'h07, e_addr:2, e_nwr:1};
        vecs[7] = '{b:{8'h12, 8'h56, 8'h55, 24'h0},         n:3, partial:0, pmp:8'h00, pmid:0, e_downl:1, e_idx:8'h07, e_addr:2, e_nwr:0};
        vecs[8] = '{b:{8'h55, 8'h09, 32'h0},                n:2, partial:0, pmp:8'hFE, pmid:0, e_downl:1, e_idx:8'h09, e_addr:0, e_nwr:0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso",  32'(miso),  32'd0);
        check("rst_downl", 32'(downl), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_addr",  32'(addr),  32'd0);
        check("rst_dout",  32'(dout),  32'd0);
        check("rst_wr",    32'(wr),    32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Directed table
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < 6; i++) f_bytes[i] = vecs[v].b[i];
            run_frame(vecs[v].n, vecs[v].partial, vecs[v].pmp, vecs[v].pmid);
            check($sformatf("vec%0d_downl", v), 32'(downl), 32'(vecs[v].e_downl));
            check($sformatf("vec%0d_index", v), 32'(index), 32'(vecs[v].e_idx));
            check($sformatf("vec%0d_addr", v),  32'(addr),  32'(vecs[v].e_addr));
            check($sformatf("vec%0d_nwr", v),   32'(got_q.size()), 32'(vecs[v].e_nwr));
            compare_frame($sformatf("vec%0d", v), vecs[v].pmp, vecs[v].n);
        end

        // Address wrap: 17 data bytes starting from address 0
        f_bytes[0] = 8'h56;
        for (int i = 1; i <= 17; i++) f_bytes[i] = 8'(8'h1F + i);
        run_frame(18, 0, 8'h66, 1'b0);
        if (got_q.size() == 17) check("wrap_17th", 32'(got_q[16]), 32'({4'h0, 8'h30}));
        else                    check("wrap_count", 32'(got_q.size()), 32'd17);
        compare_frame("wrap", 8'h66, 18);

        // Asynchronous reset in the middle of a DATA frame
        @(negedge clk);
        pump = 8'h81;
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        xfer(8'h56, 8, 1'b0, rx);
        xfer(8'hD1, 8, 1'b0, rx);
        xfer(8'hD2, 8, 1'b0, rx);
        xfer(8'hD3, 3, 1'b0, rx);
        repeat (6) @(negedge clk);
        check("midrst_pre_nwr",   32'(got_q.size()), 32'd2);
        check("midrst_pre_downl", 32'(downl), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_downl", 32'(downl), 32'd0);
        check("midrst_index", 32'(index), 32'd0);
        check("midrst_addr",  32'(addr),  32'd0);
        check("midrst_dout",  32'(dout),  32'd0);
        check("midrst_wr",    32'(wr),    32'd0);
        check("midrst_miso",  32'(miso),  32'd0);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        m_downl = 1'b0; m_idx = 8'h00; m_addr = 0;
        got_q.delete();
        exp_q.delete();
        repeat (4) @(negedge clk);
        f_bytes[0] = 8'h55; f_bytes[1] = 8'h0A;
        run_frame(2, 0, 8'h24, 1'b0);
        compare_frame("post_rst", 8'h24, 2);

        // Randomized frames against the model
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 5))
                0:       f_bytes[0] = 8'h55;
                1, 2:    f_bytes[0] = 8'h56;
                3:       f_bytes[0] = 8'h57;
                default: f_bytes[0] = 8'($urandom);
            endcase
            n = 1 + $urandom_range(0, 4);
            for (int i = 1; i < 6; i++) f_bytes[i] = 8'($urandom);
            partial = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            pmp = 8'($urandom);
            run_frame(n, partial, pmp, 1'b0);
            compare_frame($sformatf("rnd%0d", r), pmp, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_data_pump.md
# spi_data_pump

SPI-slave data pump receiver sitting directly upstream of the pump-signal stage: it accepts ROM/config downloads from the board microcontroller over SPI and presents them as a byte-wide write stream (`ioctl_*`) to the core's memories. Its `ioctl_downl_o` output drives the pump-signal stage's `download_i`. It returns that stage's `pump_o` status byte to the microcontroller on MISO so firmware can see core state.

## Interface
- `ADDR_W`, 24: width of `ioctl_addr_o`.
- `SYNC_STAGES`, 2: flip-flop stages on each SPI input (min 2).

- `clk_i`  in  1  system clock; all logic in this domain.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `spi_sck_i`  in  1  SPI clock from MCU, async; mode 0, MSB first.
- `spi_ss_n_i`  in  1  SPI select, active-low, async.
- `spi_mosi_i`  in  1  SPI data in, async.
- `spi_miso_o`  out  1  SPI data out.
- `pump_i`  in  8  status byte from pump-signal stage (`pump_o`).
- `ioctl_downl_o`  out  1  download in progress.
- `ioctl_index_o`  out  8  download target index.
- `ioctl_addr_o`  out  ADDR_W  byte address of current write.
- `ioctl_dout_o`  out  8  write data.
- `ioctl_wr_o`  out  1  one-cycle write strobe.

## Operation
- SCK, SS_N and MOSI pass through SYNC_STAGES flops; rising/falling SCK and SS_N edges detected in `clk_i` domain. `clk_i` ≥ 4× SCK frequency.
- Frame = SS_N low period. First byte is a command; the rest are payload:
  - `0x55` START: next byte is index -> `ioctl_index_o`, `ioctl_addr_o` = 0, `ioctl_downl_o` = 1. Further bytes in frame ignored.
  - `0x56` DATA: each following byte -> `ioctl_dout_o`, `ioctl_wr_o` pulse; written only while `ioctl_downl_o` = 1, else discarded.
  - `0x57` END: `ioctl_downl_o` = 0 at command-byte completion.
  - Any other value: ignore rest of frame.
- FSM: IDLE -> (SS_N fall) CMD -> START_IDX | DATA | IGNORE. In IDLE after END. SS_N rise from any state -> IDLE; partial byte discarded.
- `ioctl_downl_o`, `ioctl_index_o` persist across frames; cleared only by END or reset.
- START while downloading: address restarts at 0, index replaced, `ioctl_downl_o` stays 1.
- Address increments by 1 the cycle after each write strobe; wraps from 2^ADDR_W-1 to 0.
- MISO: `pump_i` captured on SS_N fall; bits 7..0 shifted out during command byte; 0 for all later bytes and when SS_N high.

## Timing
- Reset: `spi_miso_o`=0, `ioctl_downl_o`=0, `ioctl_index_o`=0, `ioctl_addr_o`=0, `ioctl_dout_o`=0, `ioctl_wr_o`=0, FSM=IDLE.
- MOSI sampled on detected SCK rise; MISO updated on detected SCK fall. Bit 7 on MISO within SYNC_STAGES+1 cycles of SS_N fall; MCU waits ≥ 4 `clk_i` cycles before first SCK edge.
- Byte completes on 8th detected SCK rise; action (index load, downl change, wr strobe) occurs on the next `clk_i` cycle.
- `ioctl_wr_o` high exactly 1 cycle. `ioctl_addr_o`, `ioctl_dout_o` stable on that cycle. Address changes the following cycle.
- Min spacing of 2 `ioctl_wr_o` strobes = 8 SCK periods.

## Structure
- Package `pump_pkg`: command constants (`CMD_START`, `CMD_DATA`, `CMD_END`), FSM state enum.
- Sub-module `spi_edge_sync`: N-stage synchronizer plus rise/fall pulse outputs, instantiated for SCK and SS_N. MOSI gets a plain synchronizer of equal depth to keep alignment.

## Test plan
- Reset, then frame `0x55 0x03` -> `ioctl_downl_o`=1, `ioctl_index_o`=0x03, `ioctl_addr_o`=0, no `ioctl_wr_o`.
- Frame `0x56 0xA1 0xB2 0xC3` after START -> three 1-cycle strobes with (addr,data) = (0,A1),(1,B2),(2,C3). Then `0x57` -> `ioctl_downl_o`=0.
- `pump_i`=0x3F at SS_N fall, changed to 0xFF mid-byte -> MCU reads 0x3F during command byte, 0x00 on later bytes.
- DATA frame with `ioctl_downl_o`=0 -> no strobes. SS_N raised after 5 bits of a data byte -> no strobe, next frame decodes cleanly.
- ADDR_W=4: 17 data bytes -> 17th written at address 0 (wrap). START mid-download -> address back to 0, index updated.
- `reset_n_i` low mid-download -> all outputs 0 immediately (asynchronously), FSM IDLE.
